// File: rtl/spmv_opt_issuer.sv
// Opcode issuer for the SpMV PE chain: buffers host commands and drives one word
// per cycle onto the shared opcode bus, stalling on barriers until the PEs go idle.
module spmv_opt_issuer #(
   parameter int unsigned OPT_WIDTH     = 64,
   parameter int unsigned FIFO_DEPTH    = 8,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [OPT_WIDTH-1:0] cmd_data,
   input  logic                 cmd_wait,
   output logic [OPT_WIDTH-1:0] opt_out,
   input  logic                 busy_in,
   output logic                 busy,
   output logic [31:0]          issued_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = OPT_WIDTH + 1;
   localparam int unsigned SW = 8;

   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("spmv_opt_issuer: FIFO_DEPTH must be a power of two in 2..64");
   end
   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("spmv_opt_issuer: SETTLE_CYCLES must be in 1..255");
   end

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_SETTLE = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [EW-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count, count_nxt;
   logic [SW-1:0]   settle_cnt;
   logic [EW-1:0]   head_c;
   logic            empty_c;
   logic            push_c;
   logic            pop_c;
   logic            load_settle_c;

   assign head_c    = mem[rd_ptr];
   assign empty_c   = (count == '0);
   assign push_c    = cmd_valid & cmd_ready;
   assign count_nxt = count + CW'(push_c) - CW'(pop_c);

   // Command storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= {cmd_wait, cmd_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         cmd_ready <= 1'b0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
         count     <= count_nxt;
         cmd_ready <= (count_nxt != CW'(FIFO_DEPTH));
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_RUN;
      else        state <= state_nxt;
   end

   // Next-state logic; busy_in only matters once the settle window has elapsed
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:    if (!empty_c && head_c[OPT_WIDTH]) state_nxt = ST_SETTLE;
         ST_SETTLE: if (settle_cnt == SW'(1))          state_nxt = ST_WAIT;
         ST_WAIT:   if (!busy_in)                      state_nxt = ST_RUN;
         default:                                      state_nxt = ST_RUN;
      endcase
   end

   // Output decode
   always_comb begin
      pop_c         = 1'b0;
      load_settle_c = 1'b0;
      if (state == ST_RUN && !empty_c) begin
         pop_c         = 1'b1;
         load_settle_c = head_c[OPT_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt   <= '0;
         opt_out      <= '0;
         issued_count <= '0;
         busy         <= 1'b0;
      end else begin
         if (load_settle_c)
            settle_cnt <= SW'(SETTLE_CYCLES);
         else if (state == ST_SETTLE && settle_cnt != '0)
            settle_cnt <= settle_cnt - SW'(1);
         opt_out <= pop_c ? head_c[OPT_WIDTH-1:0] : '0;
         if (pop_c) issued_count <= issued_count + 32'd1;
         busy <= (count_nxt != '0) | (state_nxt != ST_RUN) | pop_c;
      end
   end

endmodule

// File: tb/tb_spmv_opt_issuer.sv
// Scoreboard bench for spmv_opt_issuer: stimulus queues expected words, a monitor
// checks order and records issue edges for latency/gap checks.
module tb_spmv_opt_issuer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [63:0] cmd_data;
   logic        cmd_wait;
   logic [63:0] opt_out;
   logic        busy_in;
   logic        busy;
   logic [31:0] issued_count;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          n_acc = 0;
   logic [63:0] exp_q [$];
   int          iss_q [$];

   spmv_opt_issuer #(.OPT_WIDTH(64), .FIFO_DEPTH(8), .SETTLE_CYCLES(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_data     (cmd_data),
      .cmd_wait     (cmd_wait),
      .opt_out      (opt_out),
      .busy_in      (busy_in),
      .busy         (busy),
      .issued_count (issued_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out (cycle %0d)", name, cyc);
   endtask

   // Monitor: every non-NOP word must be the next expected one.
   always @(negedge clk) begin
      if (rst_n && opt_out != 64'd0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", opt_out, 64'd0);
         end else begin
            check("order", opt_out, exp_q.pop_front());
         end
         iss_q.push_back(cyc);
      end
   end

   task automatic send(input logic [63:0] d, input logic w, output int acc);
      cmd_valid = 1'b1;
      cmd_data  = d;
      cmd_wait  = w;
      acc       = -1;
      for (int n = 0; n < 300; n++) begin
         if (cmd_ready) begin
            @(negedge clk);
            acc = cyc;
            exp_q.push_back(d);
            n_acc++;
            break;
         end
         @(negedge clk);
      end
      if (acc < 0) fail_now("send");
   endtask

   task automatic idle();
      cmd_valid = 1'b0;
      cmd_data  = 64'd0;
      cmd_wait  = 1'b0;
   endtask

   task automatic wait_iss(input int n);
      for (int k = 0; k < 200; k++) begin
         if (iss_q.size() >= n) return;
         @(negedge clk);
      end
      fail_now("wait_issue");
   endtask

   task automatic wait_cyc(input int target);
      for (int k = 0; k < 200; k++) begin
         if (cyc >= target) return;
         @(negedge clk);
      end
      fail_now("wait_cycle");
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      int acc, acc0, ea;
      rst_n   = 1'b0;
      busy_in = 1'b0;
      idle();
      repeat (3) @(negedge clk);
      check("rst_opt_out", opt_out, 64'd0);
      check("rst_ready", 64'(cmd_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_count", 64'(issued_count), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 64'(cmd_ready), 64'd1);

      // Streaming: 8 words back-to-back, latency 1, no bubbles
      iss_q.delete();
      acc0 = 0;
      for (int i = 1; i <= 8; i++) begin
         send(64'h1000 + 64'(i), 1'b0, acc);
         if (i == 1) acc0 = acc;
      end
      idle();
      repeat (12) @(negedge clk);
      check("stream_n", 64'(iss_q.size()), 64'd8);
      if (iss_q.size() == 8)
         for (int i = 0; i < 8; i++) check("stream_edge", 64'(iss_q[i]), 64'(acc0 + 1 + i));
      check("stream_count", 64'(issued_count), 64'd8);
      check("stream_busy", 64'(busy), 64'd0);

      // Barrier with busy_in high for 10 cycles after A
      iss_q.delete();
      busy_in = 1'b1;
      send(64'h2001, 1'b1, acc);
      send(64'h2002, 1'b0, acc);
      idle();
      wait_iss(1);
      ea = iss_q[0];
      wait_cyc(ea + 10);
      check("wait_busy", 64'(busy), 64'd1);
      busy_in = 1'b0;
      wait_iss(2);
      if (iss_q.size() >= 2) check("barrier_busy_gap", 64'(iss_q[1] - iss_q[0]), 64'd12);

      // Barrier with busy_in low: S+1 = 5 NOP cycles
      iss_q.delete();
      send(64'h3001, 1'b1, acc);
      send(64'h3002, 1'b0, acc);
      idle();
      wait_iss(2);
      if (iss_q.size() >= 2) check("barrier_min_gap", 64'(iss_q[1] - iss_q[0]), 64'd6);

      // Settle masking: low pulse in SETTLE ignored, WAIT held 3 cycles
      iss_q.delete();
      busy_in = 1'b1;
      send(64'h3101, 1'b1, acc);
      send(64'h3102, 1'b0, acc);
      idle();
      wait_iss(1);
      ea = iss_q[0];
      wait_cyc(ea + 1);
      busy_in = 1'b0;
      wait_cyc(ea + 2);
      busy_in = 1'b1;
      wait_cyc(ea + 7);
      busy_in = 1'b0;
      wait_iss(2);
      if (iss_q.size() >= 2) check("settle_mask_gap", 64'(iss_q[1] - iss_q[0]), 64'd9);

      // Full FIFO while parked in WAIT
      iss_q.delete();
      busy_in = 1'b1;
      n_acc   = 0;
      fork
         begin
            int a;
            send(64'h4000, 1'b1, a);
            for (int i = 1; i <= 10; i++) send(64'h4000 + 64'(i), 1'b0, a);
            idle();
         end
         begin
            for (int k = 0; k < 100 && n_acc < 9; k++) @(negedge clk);
            @(negedge clk);
            check("full_ready", 64'(cmd_ready), 64'd0);
            repeat (4) @(negedge clk);
            check("full_accepts", 64'(n_acc), 64'd9);
            check("full_ready_hold", 64'(cmd_ready), 64'd0);
            check("full_busy", 64'(busy), 64'd1);
            busy_in = 1'b0;
         end
      join
      repeat (20) @(negedge clk);
      check("full_n", 64'(iss_q.size()), 64'd11);
      if (iss_q.size() == 11) check("full_drain_span", 64'(iss_q[10] - iss_q[1]), 64'd9);
      check("full_idle_ready", 64'(cmd_ready), 64'd1);

      // Reset mid-barrier with 3 queued words
      busy_in = 1'b1;
      send(64'h5000, 1'b1, acc);
      for (int i = 1; i <= 3; i++) send(64'h5000 + 64'(i), 1'b0, acc);
      idle();
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_opt_out", opt_out, 64'd0);
      check("mid_rst_ready", 64'(cmd_ready), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_count", 64'(issued_count), 64'd0);
      exp_q.delete();
      busy_in = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 64'(cmd_ready), 64'd1);
      repeat (15) @(negedge clk);
      check("post_rst_busy", 64'(busy), 64'd0);
      check("post_rst_count", 64'(issued_count), 64'd0);

      // Counter wrap
      force dut.issued_count = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.issued_count;
      for (int i = 1; i <= 3; i++) send(64'h6000 + 64'(i), 1'b0, acc);
      idle();
      repeat (6) @(negedge clk);
      check("wrap_count", 64'(issued_count), 64'h1);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
